// File: rtl/whirlpool_pkg.sv
// Whirlpool round constants and GF(2^8) helpers, shared by the forward round
// datapath and the inverse (self-test) row pipeline.
package whirlpool_pkg;

    localparam int ROW_W     = 64;
    localparam int BYTE_W    = 8;
    localparam int ROW_BYTES = ROW_W / BYTE_W;
    localparam int ROW_IDX_W = 3;

    localparam logic [ROW_IDX_W-1:0] ROW_IDX_LAST = 3'd7;
    localparam logic [8:0]           GF_POLY      = 9'h11D;

    typedef logic [3:0]                       nibble_t;
    typedef logic [BYTE_W-1:0]                gf_byte_t;
    typedef logic [ROW_W-1:0]                 row_t;
    typedef logic [ROW_BYTES-1:0][BYTE_W-1:0] coef_vec_t;

    localparam nibble_t MINI_E [16] = '{
        4'h1, 4'hB, 4'h9, 4'hC, 4'hD, 4'h6, 4'hF, 4'h3,
        4'hE, 4'h8, 4'h7, 4'h4, 4'hA, 4'h2, 4'h5, 4'h0
    };

    localparam nibble_t MINI_EI [16] = '{
        4'hF, 4'h0, 4'hD, 4'h7, 4'hB, 4'hE, 4'h5, 4'hA,
        4'h9, 4'h2, 4'hC, 4'h1, 4'h3, 4'h4, 4'h8, 4'h6
    };

    localparam nibble_t MINI_R [16] = '{
        4'h7, 4'hC, 4'hB, 4'hD, 4'hE, 4'h4, 4'h9, 4'hF,
        4'h6, 4'h3, 4'h8, 4'hA, 4'h2, 4'h5, 4'h1, 4'h0
    };

    // Element j (j = 0 in the low byte) multiplies row byte (i + j) mod 8.
    // THETA_D is the cyclic-convolution inverse of THETA_C.
    localparam coef_vec_t THETA_C = {8'h09, 8'h02, 8'h05, 8'h08, 8'h01, 8'h04, 8'h01, 8'h01};
    localparam coef_vec_t THETA_D = {8'h3E, 8'hCB, 8'hC2, 8'hC2, 8'hA4, 8'h0E, 8'hAF, 8'h04};

    function automatic gf_byte_t gf_mul(input gf_byte_t a, input gf_byte_t b);
        gf_byte_t acc;
        gf_byte_t x;
        acc = '0;
        x   = a;
        for (int i = 0; i < BYTE_W; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end
            x = {x[BYTE_W-2:0], 1'b0} ^ (x[BYTE_W-1] ? GF_POLY[BYTE_W-1:0] : 8'h00);
        end
        return acc;
    endfunction

    function automatic row_t circulant(input row_t s, input coef_vec_t coef);
        row_t     res;
        gf_byte_t acc;
        int       k;
        res = '0;
        for (int i = 0; i < ROW_BYTES; i++) begin
            acc = '0;
            for (int j = 0; j < ROW_BYTES; j++) begin
                k   = (i + j) % ROW_BYTES;
                acc = acc ^ gf_mul(coef[j], s[ROW_W-1-BYTE_W*k -: BYTE_W]);
            end
            res[ROW_W-1-BYTE_W*i -: BYTE_W] = acc;
        end
        return res;
    endfunction

    function automatic row_t theta(input row_t s);
        return circulant(s, THETA_C);
    endfunction

    function automatic row_t inv_theta(input row_t s);
        return circulant(s, THETA_D);
    endfunction

endpackage

// File: rtl/whirlpool_row_inverter_inv_gamma_byte.sv
// Inverse of the Whirlpool gamma S-box for one byte, built from the E/EI/R mini-boxes.
module inv_gamma_byte
    import whirlpool_pkg::*;
(
    input  logic [BYTE_W-1:0] row_byte,
    output logic [BYTE_W-1:0] inv_byte
);

    nibble_t a;
    nibble_t b;
    nibble_t t;

    // a^b recovers the forward l^r, so the same R output t can be stripped off both halves.
    always_comb begin
        a        = MINI_EI[row_byte[7:4]];
        b        = MINI_E[row_byte[3:0]];
        t        = MINI_R[a ^ b];
        inv_byte = {MINI_EI[a ^ t], MINI_E[b ^ t]};
    end

endmodule

// File: rtl/whirlpool_row_inverter.sv
// Two-stage valid/ready pipeline undoing theta then gamma on 64-bit rows,
// with 8-row state framing checks.
module whirlpool_row_inverter
    import whirlpool_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ROW_W-1:0] in_row,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_row,
    output logic             out_last,
    output logic             frame_err
);

    logic                 v1_reg;
    logic                 v2_reg;
    row_t                 s1_row_reg;
    logic                 s1_last_reg;
    row_t                 out_row_reg;
    logic                 out_last_reg;
    logic [ROW_IDX_W-1:0] row_idx_reg;
    logic [ROW_IDX_W-1:0] row_idx_next;
    logic                 frame_err_reg;
    logic                 frame_err_next;
    row_t                 gamma_row;
    logic                 s2_load;
    logic                 in_hs;

    assign s2_load  = ~v2_reg | out_ready;
    assign in_ready = s2_load | ~v1_reg;
    assign in_hs    = in_valid & in_ready;

    generate
        for (genvar gi = 0; gi < ROW_BYTES; gi++) begin : g_inv_gamma
            inv_gamma_byte u_inv_gamma (
                .row_byte (s1_row_reg[ROW_W-1-BYTE_W*gi -: BYTE_W]),
                .inv_byte (gamma_row[ROW_W-1-BYTE_W*gi -: BYTE_W])
            );
        end
    endgenerate

    // S1 loads whenever it is empty or its row is moving into S2 this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg      <= 1'b0;
            s1_row_reg  <= '0;
            s1_last_reg <= 1'b0;
        end else if (in_ready) begin
            v1_reg <= in_valid;
            if (in_valid) begin
                s1_row_reg  <= inv_theta(in_row);
                s1_last_reg <= in_last;
            end
        end
    end

    // The output register only changes when it is empty or being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_reg       <= 1'b0;
            out_row_reg  <= '0;
            out_last_reg <= 1'b0;
        end else if (s2_load) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                out_row_reg  <= gamma_row;
                out_last_reg <= s1_last_reg;
            end
        end
    end

    always_comb begin
        row_idx_next   = row_idx_reg;
        frame_err_next = frame_err_reg;
        if (in_hs) begin
            if (in_last) begin
                row_idx_next = '0;
                if (row_idx_reg != ROW_IDX_LAST) begin
                    frame_err_next = 1'b1;
                end
            end else begin
                row_idx_next = row_idx_reg + 3'd1;
                if (row_idx_reg == ROW_IDX_LAST) begin
                    frame_err_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_idx_reg   <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            row_idx_reg   <= row_idx_next;
            frame_err_reg <= frame_err_next;
        end
    end

    assign out_valid = v2_reg;
    assign out_row   = out_row_reg;
    assign out_last  = out_last_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_whirlpool_row_inverter.sv
// Directed and streamed checks of the Whirlpool row inverter against a forward round model.
module tb_whirlpool_row_inverter;

    localparam int B2B_ROWS = 1000;
    localparam int BP_ROWS  = 200;

    localparam logic [3:0] TB_E [16] = '{
        4'h1, 4'hB, 4'h9, 4'hC, 4'hD, 4'h6, 4'hF, 4'h3,
        4'hE, 4'h8, 4'h7, 4'h4, 4'hA, 4'h2, 4'h5, 4'h0
    };
    localparam logic [3:0] TB_EI [16] = '{
        4'hF, 4'h0, 4'hD, 4'h7, 4'hB, 4'hE, 4'h5, 4'hA,
        4'h9, 4'h2, 4'hC, 4'h1, 4'h3, 4'h4, 4'h8, 4'h6
    };
    localparam logic [3:0] TB_R [16] = '{
        4'h7, 4'hC, 4'hB, 4'hD, 4'hE, 4'h4, 4'h9, 4'hF,
        4'h6, 4'h3, 4'h8, 4'hA, 4'h2, 4'h5, 4'h1, 4'h0
    };
    localparam logic [7:0] TB_C [8] = '{8'h01, 8'h01, 8'h04, 8'h01, 8'h08, 8'h05, 8'h02, 8'h09};

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_row;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_row;
    logic        out_last;
    logic        frame_err;

    int checks;
    int failures;

    whirlpool_row_inverter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    // Golden forward round: gamma S-box per byte, then the theta circulant.
    function automatic logic [63:0] fwd_row(input logic [63:0] pre);
        logic [7:0]  s [8];
        logic [3:0]  l, r, t;
        logic [7:0]  acc;
        logic [63:0] res;
        for (int i = 0; i < 8; i++) begin
            l    = TB_E[pre[63-8*i -: 4]];
            r    = TB_EI[pre[59-8*i -: 4]];
            t    = TB_R[l ^ r];
            s[i] = {TB_E[l ^ t], TB_EI[r ^ t]};
        end
        res = 64'h0;
        for (int i = 0; i < 8; i++) begin
            acc = 8'h00;
            for (int j = 0; j < 8; j++) acc = acc ^ tb_mul(TB_C[j], s[(i + j) % 8]);
            res[63-8*i -: 8] = acc;
        end
        return res;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_row    = 64'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_row !== 64'h0) begin failures++; $display("FAIL reset_out_row got=%h exp=0", out_row); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (dut.row_idx_reg !== 3'd0) begin failures++; $display("FAIL reset_row_idx got=%0d exp=0", dut.row_idx_reg); end
        $display("test_reset done");
    endtask

    task automatic test_single_row();
        logic [63:0] vec_in  [2];
        logic [63:0] vec_exp [2];
        vec_in[0]  = 64'h2828_2828_2828_2828; vec_exp[0] = 64'h0;
        vec_in[1]  = 64'hD65E_FFED_13C4_1313; vec_exp[1] = 64'h0000_0000_0000_0001;
        for (int v = 0; v < 2; v++) begin
            do_reset();
            @(negedge clk);
            in_row = vec_in[v]; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0; in_row = 64'h0;
            #1;
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid vec=%0d got=%b exp=0", v, out_valid); end
            @(negedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_row !== vec_exp[v]) begin
                failures++; $display("FAIL single_row vec=%0d got valid=%b row=%h exp valid=1 row=%h", v, out_valid, out_row, vec_exp[v]);
            end
            @(negedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_one_cycle vec=%0d got=%b exp=0", v, out_valid); end
            $display("single row vec=%0d in=%h out=%h", v, vec_in[v], vec_exp[v]);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] pre_q [$];
        logic [63:0] pre, exp_row;
        int sent, got, cyc, stalls;
        do_reset();
        sent = 0; got = 0; cyc = 0; stalls = 0; pre = 64'h0;
        out_ready = 1'b1;
        while (got < B2B_ROWS && cyc < B2B_ROWS + 50) begin
            @(negedge clk);
            if (sent < B2B_ROWS) begin
                pre = {$urandom, $urandom};
                in_row = fwd_row(pre); in_last = (sent % 8 == 7); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            #1;
            if (out_valid === 1'b1) begin
                checks++;
                if (pre_q.size() == 0) begin
                    failures++; $display("FAIL b2b_spurious got row=%h exp no output", out_row);
                end else begin
                    exp_row = pre_q.pop_front();
                    if (out_row !== exp_row) begin failures++; $display("FAIL b2b_row idx=%0d got=%h exp=%h", got, out_row, exp_row); end
                end
                got++;
            end
            if (in_valid) begin
                if (in_ready === 1'b1) begin pre_q.push_back(pre); sent++; end
                else stalls++;
            end
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (cyc != B2B_ROWS + 2 || stalls != 0) begin
            failures++; $display("FAIL b2b_throughput got cycles=%0d stalls=%0d exp cycles=%0d stalls=0", cyc, stalls, B2B_ROWS + 2);
        end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL b2b_frame_err got=%b exp=0", frame_err); end
        $display("back_to_back rows=%0d cycles=%0d", got, cyc);
    endtask

    task automatic test_backpressure();
        logic [64:0] exp_q [$];
        logic [64:0] exp_ent;
        logic [63:0] pre, hold_row;
        logic        hold_last, hold_valid, pending;
        int sent, got, cyc;
        do_reset();
        sent = 0; got = 0; cyc = 0; pre = 64'h0;
        hold_valid = 1'b0; hold_row = 64'h0; hold_last = 1'b0; pending = 1'b0;
        while (got < BP_ROWS && cyc < 5000) begin
            @(negedge clk);
            if (!pending && sent < BP_ROWS) begin
                pre = {$urandom, $urandom};
                in_row = fwd_row(pre); in_last = (sent % 8 == 7); in_valid = 1'b1; pending = 1'b1;
            end else if (!pending) begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (hold_valid) begin
                checks++;
                if (out_valid !== 1'b1 || out_row !== hold_row || out_last !== hold_last) begin
                    failures++; $display("FAIL bp_hold got valid=%b row=%h last=%b exp valid=1 row=%h last=%b", out_valid, out_row, out_last, hold_row, hold_last);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL bp_spurious got row=%h exp no output", out_row);
                end else begin
                    exp_ent = exp_q.pop_front();
                    if ({out_last, out_row} !== exp_ent) begin
                        failures++; $display("FAIL bp_row idx=%0d got last=%b row=%h exp last=%b row=%h", got, out_last, out_row, exp_ent[64], exp_ent[63:0]);
                    end
                end
                got++;
            end
            hold_valid = (out_valid === 1'b1) && !out_ready;
            hold_row   = out_row;
            hold_last  = out_last;
            if (in_valid && in_ready === 1'b1) begin
                exp_q.push_back({in_last, pre}); sent++; pending = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        checks++;
        if (got != BP_ROWS || exp_q.size() != 0) begin
            failures++; $display("FAIL bp_count got=%0d left=%0d exp=%0d left=0", got, exp_q.size(), BP_ROWS);
        end
        $display("backpressure rows=%0d cycles=%0d", got, cyc);
    endtask

    task automatic test_state_framing();
        logic [63:0] pre [8];
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k < 8) begin
                pre[k] = {$urandom, $urandom};
                in_row = fwd_row(pre[k]); in_last = (k == 7); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            #1;
            if (k >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_row !== pre[k-2] || out_last !== (k == 9)) begin
                    failures++; $display("FAIL frame_row idx=%0d got valid=%b row=%h last=%b exp valid=1 row=%h last=%b", k - 2, out_valid, out_row, out_last, pre[k-2], (k == 9));
                end
            end
        end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL frame_ok_err got=%b exp=0", frame_err); end
        checks++; if (dut.row_idx_reg !== 3'd0) begin failures++; $display("FAIL frame_ok_idx got=%0d exp=0", dut.row_idx_reg); end
        $display("state framing 8 rows done");
    endtask

    task automatic test_frame_error();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_row = 64'h1111_0000_0000_0000 + 64'(k); in_last = (k == 3); in_valid = 1'b1;
            #1;
            if (k == 3) begin
                checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_early got=%b exp=0", frame_err); end
            end
        end
        @(negedge clk);
        in_last = 1'b0;
        #1;
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_rise got=%b exp=1", frame_err); end
        checks++; if (dut.row_idx_reg !== 3'd0) begin failures++; $display("FAIL ferr_idx_clear got=%0d exp=0", dut.row_idx_reg); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (dut.row_idx_reg !== 3'd1) begin failures++; $display("FAIL ferr_idx_next got=%0d exp=1", dut.row_idx_reg); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_sticky got=%b exp=1", frame_err); end
        $display("frame error early last done");

        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_row = 64'h2222_0000_0000_0000 + 64'(k); in_last = 1'b0; in_valid = 1'b1;
            #1;
            if (k == 7) begin
                checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_missing_early got=%b exp=0", frame_err); end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_missing_last got=%b exp=1", frame_err); end
        checks++; if (dut.row_idx_reg !== 3'd0) begin failures++; $display("FAIL ferr_wrap_idx got=%0d exp=0", dut.row_idx_reg); end
        $display("frame error missing last done");
    endtask

    task automatic test_reset_midstream();
        logic [63:0] a, b, c;
        a = 64'h0123_4567_89AB_CDEF;
        b = 64'h0F1E_2D3C_4B5A_6978;
        c = 64'hFEDC_BA98_7654_3210;
        do_reset();
        out_ready = 1'b0;
        @(negedge clk);
        in_row = fwd_row(a); in_last = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_row = fwd_row(b); in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || frame_err !== 1'b1 || out_row !== a) begin
            failures++; $display("FAIL mid_prefill got valid=%b err=%b row=%h exp valid=1 err=1 row=%h", out_valid, frame_err, out_row, a);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL mid_rst_err got=%b exp=0", frame_err); end
        checks++; if (out_row !== 64'h0 || out_last !== 1'b0) begin failures++; $display("FAIL mid_rst_row got row=%h last=%b exp row=0 last=0", out_row, out_last); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        in_row = fwd_row(c); in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale_out got=%b exp=0", out_valid); end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_row !== c) begin
            failures++; $display("FAIL mid_first_out got valid=%b row=%h exp valid=1 row=%h", out_valid, out_row, c);
        end
        $display("reset midstream first out=%h", out_row);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_row();
        test_back_to_back();
        test_backpressure();
        test_state_framing();
        test_frame_error();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
